// File: rtl/mlp_act_buffer.sv
// Ping-pong activation buffer between the MLP I/O and its N neurons.
// Optional: define MLP_ACT_RELU_EN to apply ReLU to captured neuron outputs.
module mlp_act_buffer #(
  parameter int N = 2,
  parameter int W = 8,
  parameter int M = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*W-1:0]         in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   init,
  input  logic                   read_en,
  input  logic                   write_en,
  input  logic                   done,
  input  logic [$clog2(M-1)-1:0] layer_addr,
  output logic [N*W-1:0]         act_out,
  input  logic [N*W-1:0]         nout,
  input  logic                   nout_valid,
  output logic [N*W-1:0]         result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   err
);

  localparam int CW = $clog2(M);
  localparam logic [CW-1:0] LAST_LAYER = CW'(M - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, OUT} state_t;

  state_t           state_q, state_d;
  logic [N*W-1:0]   bank_q [2];
  logic [N*W-1:0]   bank_d [2];
  logic             sel_q, sel_d;
  logic [CW-1:0]    layer_cnt_q, layer_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             init_q, init_d;
  logic             result_valid_q, result_valid_d;
  logic             err_q, err_d;
  logic [N*W-1:0]   cap_data;
  logic [CW-1:0]    layer_addr_ext;

  assign layer_addr_ext = CW'(layer_addr);

`ifdef MLP_ACT_RELU_EN
  always_comb begin
    cap_data = nout;
    for (int i = 0; i < N; i++) begin
      if (nout[i*W + W-1]) cap_data[i*W +: W] = '0;
    end
  end
`else
  assign cap_data = nout;
`endif

  // NOTE: every signal gets its hold value first so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    sel_d       = sel_q;
    layer_cnt_d = layer_cnt_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bank_d[0]   = in_data;
          sel_d       = 1'b0;
          layer_cnt_d = '0;
          state_d     = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (nout_valid) begin
          if (write_en) begin
            bank_d[~sel_q] = cap_data;
            sel_d          = ~sel_q;
            // Saturated counter: the extra capture is kept but flagged.
            if (layer_cnt_q == LAST_LAYER) err_d = 1'b1;
            else                           layer_cnt_d = layer_cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (read_en && (layer_addr_ext != layer_cnt_q)) err_d = 1'b1;
        if (done) begin
          state_d = OUT;
          if (layer_cnt_d != LAST_LAYER) err_d = 1'b1;
        end
      end
      OUT: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d     = (state_d == IDLE);
    init_d         = (state_d == START);
    result_valid_d = (state_d == OUT);
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sel_q          <= 1'b0;
      layer_cnt_q    <= '0;
      in_ready_q     <= 1'b1;
      init_q         <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      // NOTE: the banks are reset deliberately so act_out is zero straight after reset.
      bank_q[0]      <= '0;
      bank_q[1]      <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      layer_cnt_q    <= layer_cnt_d;
      in_ready_q     <= in_ready_d;
      init_q         <= init_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      bank_q[0]      <= bank_d[0];
      bank_q[1]      <= bank_d[1];
    end
  end

  assign act_out      = bank_q[sel_q];
  assign result       = bank_q[sel_q];
  assign in_ready     = in_ready_q;
  assign init         = init_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mlp_act_buffer.sv
// Directed bench for mlp_act_buffer: table-driven cycle vectors plus backpressure and ReLU sequences.
module tb_mlp_act_buffer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, init, read_en, write_en, done;
  logic [0:0]  layer_addr;
  logic [15:0] in_data, act_out, nout, result;
  logic        nout_valid, result_valid, result_ready, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mlp_act_buffer #(.N(2), .W(8), .M(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .init(init), .read_en(read_en), .write_en(write_en), .done(done),
    .layer_addr(layer_addr), .act_out(act_out), .nout(nout), .nout_valid(nout_valid),
    .result(result), .result_valid(result_valid), .result_ready(result_ready), .err(err)
  );

  typedef struct {
    logic        rst, iv;
    logic [15:0] din;
    logic        re, we, dn, la;
    logic [15:0] nout;
    logic        nv, rr;
    logic        e_rdy, e_init, e_rv, e_err;
    logic [15:0] e_act;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 0; in_valid = 0; in_data = '0; read_en = 0; write_en = 0; done = 0;
    layer_addr = '0; nout = '0; nout_valid = 0; result_ready = 0;
  endtask

  task automatic capture(input logic [15:0] v, input logic la);
    idle_in();
    read_en = 1; layer_addr = la; write_en = 1; nout_valid = 1; nout = v;
    step();
    idle_in();
  endtask

  initial begin
    idle_in();
    //                 rst iv din      re we dn la nout     nv rr  rdy ini rv er act
    // basic inference; in_valid during RUN must be ignored
    vq.push_back(vec_t'{1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000});
    vq.push_back(vec_t'{0, 1, 16'h0503, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0503});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0503});
    vq.push_back(vec_t'{0, 1, 16'hFFFF, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0503});
    vq.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 0, 0, 16'h1020, 1, 0, 0, 0, 0, 0, 16'h1020});
    vq.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h1020});
    vq.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 0, 1, 16'h0701, 1, 0, 0, 0, 0, 0, 16'h0701});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 16'h0701});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0701});
    // dropped output, then early done: err sticks, result is layer-1 output
    vq.push_back(vec_t'{0, 1, 16'h1122, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h1122});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h1122});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 1, 0, 0, 0, 0, 1, 16'h1122});
    vq.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 0, 0, 16'h3344, 1, 0, 0, 0, 0, 1, 16'h3344});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 16'h3344});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 1, 16'h3344});
    // reset after the first capture
    vq.push_back(vec_t'{0, 1, 16'h0503, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 16'h0503});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0503});
    vq.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 0, 0, 16'h1020, 1, 0, 0, 0, 0, 1, 16'h1020});
    vq.push_back(vec_t'{1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000});
    // fresh inference, final capture and done in the same cycle
    vq.push_back(vec_t'{0, 1, 16'h0503, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0503});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0503});
    vq.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 0, 0, 16'h1020, 1, 0, 0, 0, 0, 0, 16'h1020});
    vq.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 1, 1, 16'h0701, 1, 0, 0, 0, 1, 0, 16'h0701});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0701});
    // layer_addr disagreeing with the layer count
    vq.push_back(vec_t'{0, 1, 16'h0A0B, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0A0B});
    vq.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0A0B});
    vq.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0A0B});
    vq.push_back(vec_t'{1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000});

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; in_valid = vq[i].iv; in_data = vq[i].din;
      read_en = vq[i].re; write_en = vq[i].we; done = vq[i].dn; layer_addr = vq[i].la;
      nout = vq[i].nout; nout_valid = vq[i].nv; result_ready = vq[i].rr;
      step();
      check($sformatf("v%0d.in_ready", i), {15'd0, in_ready}, {15'd0, vq[i].e_rdy});
      check($sformatf("v%0d.init", i), {15'd0, init}, {15'd0, vq[i].e_init});
      check($sformatf("v%0d.result_valid", i), {15'd0, result_valid}, {15'd0, vq[i].e_rv});
      check($sformatf("v%0d.err", i), {15'd0, err}, {15'd0, vq[i].e_err});
      check($sformatf("v%0d.act_out", i), act_out, vq[i].e_act);
      if (vq[i].e_rv) check($sformatf("v%0d.result", i), result, vq[i].e_act);
    end

    // backpressure: result held for five cycles with result_ready low
    idle_in();
    in_valid = 1; in_data = 16'h0503;
    step();
    idle_in();
    step();
    capture(16'h1020, 1'b0);
    capture(16'h0701, 1'b1);
    done = 1;
    step();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.result_valid", i), {15'd0, result_valid}, 16'd1);
      check($sformatf("bp%0d.result", i), result, 16'h0701);
      check($sformatf("bp%0d.in_ready", i), {15'd0, in_ready}, 16'd0);
      step();
    end
    check("bp.hs_in_ready", {15'd0, in_ready}, 16'd0);
    result_ready = 1;
    step();
    idle_in();
    check("bp.post_result_valid", {15'd0, result_valid}, 16'd0);
    check("bp.post_in_ready", {15'd0, in_ready}, 16'd1);
    check("bp.post_err", {15'd0, err}, 16'd0);

    // capture path with a negative word; input vectors are never altered
    in_valid = 1; in_data = 16'h8001;
    step();
    idle_in();
    check("relu.in_unchanged", act_out, 16'h8001);
    step();
    capture(16'hF012, 1'b0);
`ifdef MLP_ACT_RELU_EN
    check("relu.act_out", act_out, 16'h0012);
`else
    check("relu.act_out", act_out, 16'hF012);
`endif
    done = 1;
    step();
    idle_in();
    result_ready = 1;
    step();
    idle_in();
    check("relu.back_idle", {15'd0, in_ready}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
